// File: rtl/router_pkg.sv
// router_pkg: shared router types and default constants.
package router_pkg;
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  localparam int DEFAULT_MAX_LOCK = 16;
endpackage

// File: rtl/binary_to_onehot.sv
// binary_to_onehot: combinational index to one-hot decode with range flag.
module binary_to_onehot #(
  parameter int NUM_OUTPUTS = 4,
  parameter int NUM_BITS    = $clog2(NUM_OUTPUTS)
) (
  input  logic [NUM_BITS-1:0]    i_index,
  output logic [NUM_OUTPUTS-1:0] o_onehot,
  output logic                   o_in_range
);
  assign o_in_range = int'(i_index) < NUM_OUTPUTS;
  assign o_onehot   = o_in_range ? {{(NUM_OUTPUTS-1){1'b0}}, 1'b1} << i_index : '0;
endmodule

// File: rtl/grant_lock_decoder.sv
// grant_lock_decoder: latches an allocator grant as a one-hot select held until release or watchdog expiry.
module grant_lock_decoder
  import router_pkg::*;
#(
  parameter int NUM_OUTPUTS = 4,
  parameter int NUM_BITS    = $clog2(NUM_OUTPUTS),
  parameter int MAX_LOCK    = DEFAULT_MAX_LOCK,
  parameter int CNT_BITS    = $clog2(MAX_LOCK + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [NUM_BITS-1:0]    in_index,
  output logic                   in_ready,
  input  logic                   in_release,
  output logic [NUM_OUTPUTS-1:0] out_grant,
  output logic                   out_valid,
  output logic                   err_range,
  output logic                   timeout
);
  lock_state_t             r_state;
  logic [CNT_BITS-1:0]     r_lock_cnt;
  logic [NUM_OUTPUTS-1:0]  r_grant;
  logic                    r_err_range;
  logic                    r_timeout;
  logic [NUM_OUTPUTS-1:0]  w_onehot;
  logic                    w_in_range;
  logic                    w_expire;
  logic                    w_end;
  logic                    w_accept;

  binary_to_onehot #(.NUM_OUTPUTS(NUM_OUTPUTS), .NUM_BITS(NUM_BITS)) u_dec (
    .i_index   (in_index),
    .o_onehot  (w_onehot),
    .o_in_range(w_in_range)
  );

  assign w_expire = (r_state == LOCKED) && (r_lock_cnt == CNT_BITS'(MAX_LOCK - 1));
  assign w_end    = (r_state == LOCKED) && (in_release || w_expire);
  assign in_ready = (r_state == IDLE) || w_end;
  assign w_accept = in_valid && in_ready && w_in_range;

  // Release takes priority over expiry, so the watchdog pulse is suppressed when both coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lock_cnt  <= '0;
      r_grant     <= '0;
      r_err_range <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_err_range <= in_valid && in_ready && !w_in_range;
      r_timeout   <= w_expire && !in_release;
      if (w_accept) begin
        r_state    <= LOCKED;
        r_grant    <= w_onehot;
        r_lock_cnt <= '0;
      end else if (w_end) begin
        r_state    <= IDLE;
        r_grant    <= '0;
        r_lock_cnt <= '0;
      end else if (r_state == LOCKED) begin
        r_lock_cnt <= r_lock_cnt + CNT_BITS'(1);
      end
    end
  end

  assign out_grant = r_grant;
  assign out_valid = r_state == LOCKED;
  assign err_range = r_err_range;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_grant_lock_decoder.sv
// tb_grant_lock_decoder: directed and random stimulus checked against a packet-level lock model.
module tb_grant_lock_decoder;
  localparam int N  = 3;
  localparam int ML = 4;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [1:0]   in_index = '0;
  logic         in_release = 1'b0;
  logic         in_ready;
  logic [N-1:0] out_grant;
  logic         out_valid;
  logic         err_range;
  logic         timeout;
  int n_tests = 0;
  int n_fail  = 0;
  int owner   = -1;
  int held    = 0;
  bit m_err   = 1'b0;
  bit m_to    = 1'b0;

  grant_lock_decoder #(.NUM_OUTPUTS(N), .MAX_LOCK(ML)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_index  (in_index),
    .in_ready  (in_ready),
    .in_release(in_release),
    .out_grant (out_grant),
    .out_valid (out_valid),
    .err_range (err_range),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit v, input int idx, input bit rel);
    bit rdy, ending, acc;
    @(negedge clk);
    reset = rst;
    in_valid = v;
    in_index = 2'(idx);
    in_release = rel;
    #1;
    rdy = owner < 0 || rel || held == ML - 1;
    if (!rst) chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    if (rst) begin
      owner = -1;
      held  = 0;
      m_err = 1'b0;
      m_to  = 1'b0;
    end else begin
      ending = owner >= 0 && (rel || held == ML - 1);
      m_to   = owner >= 0 && !rel && held == ML - 1;
      acc    = v && rdy && idx < N;
      m_err  = v && rdy && idx >= N;
      if (acc) begin
        owner = idx;
        held  = 0;
      end else if (ending) begin
        owner = -1;
        held  = 0;
      end else if (owner >= 0) begin
        held++;
      end
    end
    #1;
    chk("out_grant", 32'(out_grant), owner < 0 ? 32'd0 : 32'd1 << owner);
    chk("out_valid", 32'(out_valid), 32'(owner >= 0));
    chk("err_range", 32'(err_range), 32'(m_err));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("onehot0", 32'($onehot0(out_grant)), 32'd1);
    chk("valid_eq_any", 32'(out_valid), 32'(|out_grant));
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 2, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 2, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 3, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, int'($urandom_range(0, 3)), 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 3, 1);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(1, 1, 2, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
           int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
